// File: rtl/stoch_ctrl_pkg.sv
// Shared types and sizing helpers for the stochastic divider window sequencer.
//   stoch_win_state_t : sequencer FSM state encoding
//   cnt_width()       : ones-counter width able to hold WINDOW_LEN
//   max3()            : largest of three values (phase counter sizing)
package stoch_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      VALID = 3'd4
   } stoch_win_state_t;

   // Width needed to represent 0..window_len inclusive.
   function automatic int unsigned cnt_width(input int unsigned window_len);
      return $clog2(window_len + 1);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/stoch_ones_counter.sv
// Per-element ones counter for one divider output bitstream.
//   CLK, nRST : clock, async active-low reset
//   clr       : synchronous clear (window start / abort)
//   en        : count qualifier (latency-aligned bit enable)
//   bit_in    : divider output bit
//   cnt       : number of qualified ones seen since the last clear
module stoch_ones_counter #(
   parameter int unsigned CNT_W = 9
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CNT_W-1:0] cnt
);

   // Cannot overflow: the window bounds the number of qualified samples.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)             cnt <= '0;
      else if (clr)          cnt <= '0;
      else if (en && bit_in) cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/stoch_div_window_ctrl.sv
// Window sequencer for a NUM_ROWS x NUM_COLS stochastic divider array.
// Flushes the array in reset, enables the bitstream generators for WINDOW_LEN
// cycles, counts ones on every divider output (aligned by DIV_LAT) and presents
// the counts through a valid/ready handshake.
//   CLK, nRST    : clock, async active-low reset
//   start        : begin a window (only honoured in IDLE)
//   busy         : sequencer not idle
//   div_nRST     : active-low reset to the divider array
//   bit_en       : bitstream generator enable
//   Y_in         : divider output bits
//   count        : per-element ones counts (decoded results)
//   result_valid : counts final; result_ready accepts them
//   abort        : only with STOCH_DIV_CTRL_ABORT_EN defined; returns to IDLE
module stoch_div_window_ctrl
   import stoch_ctrl_pkg::*;
#(
   parameter  int unsigned NUM_ROWS     = 2,
   parameter  int unsigned NUM_COLS     = 2,
   parameter  int unsigned WINDOW_LEN   = 256,
   parameter  int unsigned FLUSH_CYCLES = 2,
   parameter  int unsigned DIV_LAT      = 1,
   localparam int unsigned CNT_W        = cnt_width(WINDOW_LEN)
) (
   input  logic                                      CLK,
   input  logic                                      nRST,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      div_nRST,
   output logic                                      bit_en,
   input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]            Y_in,
   output logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0] count,
   output logic                                      result_valid,
   input  logic                                      result_ready
`ifdef STOCH_DIV_CTRL_ABORT_EN
   ,input logic                                      abort
`endif
);

   localparam int unsigned PH_MAX   = max3(FLUSH_CYCLES, WINDOW_LEN, DIV_LAT);
   localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
   localparam int unsigned FL_LAST  = FLUSH_CYCLES - 1;
   localparam int unsigned WIN_LAST = WINDOW_LEN - 1;
   localparam int unsigned DR_LAST  = (DIV_LAT > 0) ? DIV_LAT - 1 : 0;

   stoch_win_state_t state, state_next;
   logic [PH_W-1:0]  phase, phase_next;
   logic             abort_evt;
   logic             clr;
   logic             cnt_en;

`ifdef STOCH_DIV_CTRL_ABORT_EN
   assign abort_evt = abort && (state != IDLE);
`else
   assign abort_evt = 1'b0;
`endif

   // State and phase registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         phase <= '0;
      end else begin
         state <= state_next;
         phase <= phase_next;
      end
   end

   // Next-state; phase counts cycles spent in the current state.
   always_comb begin
      state_next = state;
      phase_next = phase + PH_W'(1);
      case (state)
         IDLE: begin
            phase_next = '0;
            if (start) state_next = FLUSH;
         end
         FLUSH: if (phase == PH_W'(FL_LAST)) begin
            state_next = RUN;
            phase_next = '0;
         end
         RUN: if (phase == PH_W'(WIN_LAST)) begin
            state_next = (DIV_LAT == 0) ? VALID : DRAIN;
            phase_next = '0;
         end
         DRAIN: if (phase == PH_W'(DR_LAST)) begin
            state_next = VALID;
            phase_next = '0;
         end
         VALID: begin
            phase_next = '0;
            if (result_ready) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            phase_next = '0;
         end
      endcase
`ifdef STOCH_DIV_CTRL_ABORT_EN
      // Abort wins over everything, and also blocks a start while idle.
      if (abort) begin
         state_next = (state == IDLE) ? IDLE : IDLE;
         phase_next = '0;
      end
`endif
   end

   // Window start or abort wipes counts and the latency pipe.
   assign clr = ((state == IDLE) && (state_next == FLUSH)) || abort_evt;

   // Outputs registered from the next state so they track the state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy         <= 1'b0;
         div_nRST     <= 1'b0;
         bit_en       <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         busy         <= (state_next != IDLE);
         div_nRST     <= (state_next == RUN) || (state_next == DRAIN) ||
                         (state_next == VALID);
         bit_en       <= (state_next == RUN);
         result_valid <= (state_next == VALID);
      end
   end

   // cnt_en follows bit_en through the divider latency.
   generate
      if (DIV_LAT == 0) begin : g_lat0
         assign cnt_en = bit_en;
      end else begin : g_lat
         logic [DIV_LAT-1:0] lat_sr;
         logic [DIV_LAT:0]   lat_nxt;
         assign lat_nxt = {lat_sr, bit_en};
         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST)    lat_sr <= '0;
            else if (clr) lat_sr <= '0;
            else          lat_sr <= lat_nxt[DIV_LAT-1:0];
         end
         assign cnt_en = lat_sr[DIV_LAT-1];
      end
   endgenerate

   // One ones counter per array element.
   generate
      for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
         for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
            stoch_ones_counter #(.CNT_W(CNT_W)) u_cnt (
               .CLK    (CLK),
               .nRST   (nRST),
               .clr    (clr),
               .en     (cnt_en),
               .bit_in (Y_in[i][j]),
               .cnt    (count[i][j])
            );
         end
      end
   endgenerate

endmodule

// File: tb/tb_stoch_div_window_ctrl.sv
// Self-checking bench for stoch_div_window_ctrl: a default instance (DIV_LAT=1)
// and a DIV_LAT=3 instance driven by a latency-3 divider model.
module tb_stoch_div_window_ctrl;

   localparam int CW = 9;
   localparam int W  = 256;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic start0 = 1'b0, rdy0 = 1'b0, abort0 = 1'b0;
   logic busy0, dnr0, ben0, rv0;
   logic [1:0][1:0]         y0;
   logic [1:0][1:0][CW-1:0] cnt0;
   // DIV_LAT=3 instance
   logic start3 = 1'b0, rdy3 = 1'b0, abort3 = 1'b0;
   logic busy3, dnr3, ben3, rv3;
   logic [1:0][1:0]         y3;
   logic [1:0][1:0][CW-1:0] cnt3;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  sb_q[$];

   // stimulus model for instance 0: 0 = zeros, 1 = all ones, 2 = [0][1] toggles
   int   mode = 0;
   logic ytog = 1'b0;
   always @(posedge clk) ytog <= ~ytog;
   assign y0 = (mode == 1) ? 4'b1111 : (mode == 2) ? {2'b00, ytog, 1'b0} : 4'b0000;

   // divider model for instance 3: generators emit 1 for the first 3 enabled
   // cycles, the divider returns that stream 3 cycles later
   int       gidx = 0;
   logic [2:0] pipe = 3'b000;
   always @(posedge clk) begin
      gidx <= ben3 ? gidx + 1 : 0;
      pipe <= {pipe[1:0], ben3 && (gidx < 3)};
   end
   assign y3 = {4{pipe[2]}};

   stoch_div_window_ctrl u_dut0 (
      .CLK(clk), .nRST(nrst), .start(start0), .busy(busy0), .div_nRST(dnr0),
      .bit_en(ben0), .Y_in(y0), .count(cnt0), .result_valid(rv0),
      .result_ready(rdy0)
`ifdef STOCH_DIV_CTRL_ABORT_EN
      , .abort(abort0)
`endif
   );

   stoch_div_window_ctrl #(.DIV_LAT(3)) u_dut3 (
      .CLK(clk), .nRST(nrst), .start(start3), .busy(busy3), .div_nRST(dnr3),
      .bit_en(ben3), .Y_in(y3), .count(cnt3), .result_valid(rv3),
      .result_ready(rdy3)
`ifdef STOCH_DIV_CTRL_ABORT_EN
      , .abort(abort3)
`endif
   );

   // Pulse start, then step edges until result_valid; reports the edge index
   // (start edge = 0, -1 on timeout) and number of cycles bit_en was high.
   task automatic run_window(input int which, output int vedge, output int nben);
      vedge = -1;
      nben  = 0;
      if (which == 0) start0 = 1'b1; else start3 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start3 = 1'b0;
      for (int e = 1; e <= 700; e++) begin
         @(posedge clk); #1;
         if (((which == 0) ? ben0 : ben3) === 1'b1) nben++;
         if (((which == 0) ? rv0 : rv3) === 1'b1) begin
            vedge = e;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy0, dnr0, ben0, rv0} !== 4'b0000) $display("FAIL reset_ctrl0 got %b expected 0000", {busy0, dnr0, ben0, rv0});
      else n_pass++;
      n_checks++;
      if ({busy3, dnr3, ben3, rv3} !== 4'b0000) $display("FAIL reset_ctrl3 got %b expected 0000", {busy3, dnr3, ben3, rv3});
      else n_pass++;
      n_checks++;
      if (cnt0 !== '0) $display("FAIL reset_count0 got %h expected 0", cnt0);
      else n_pass++;
      nrst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pop_check0(input string name);
      int exp;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL %s[%0d][%0d] scoreboard empty, got %0d", name, i, j, cnt0[i][j]);
            end else begin
               exp = sb_q.pop_front();
               if (int'(cnt0[i][j]) !== exp) $display("FAIL %s[%0d][%0d] got %0d expected %0d", name, i, j, cnt0[i][j], exp);
               else n_pass++;
            end
         end
   endtask

   task automatic test_all_ones();
      int ve, nb;
      mode = 1;
      repeat (4) sb_q.push_back(W);
      run_window(0, ve, nb);
      n_checks++;
      if (ve !== 259) $display("FAIL ones_valid_edge got %0d expected 259", ve);
      else n_pass++;
      n_checks++;
      if (nb !== W) $display("FAIL ones_bit_en_cycles got %0d expected %0d", nb, W);
      else n_pass++;
      n_checks++;
      if ({busy0, dnr0, ben0} !== 3'b110) $display("FAIL ones_valid_ctrl got %b expected 110", {busy0, dnr0, ben0});
      else n_pass++;
      pop_check0("ones_count");
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
      n_checks++;
      if ({busy0, rv0, dnr0} !== 3'b000) $display("FAIL ones_accept got %b expected 000", {busy0, rv0, dnr0});
      else n_pass++;
   endtask

   task automatic test_toggle();
      int ve, nb;
      mode = 2;
      sb_q.push_back(0); sb_q.push_back(W / 2); sb_q.push_back(0); sb_q.push_back(0);
      run_window(0, ve, nb);
      n_checks++;
      if (ve !== 259) $display("FAIL toggle_valid_edge got %0d expected 259", ve);
      else n_pass++;
      pop_check0("toggle_count");
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (int'(cnt0[0][1]) !== W / 2 || cnt0[0][0] !== '0) $display("FAIL toggle_idle_hold got %0d/%0d expected %0d/0", cnt0[0][1], cnt0[0][0], W / 2);
      else n_pass++;
      n_checks++;
      if (busy0 !== 1'b0) $display("FAIL toggle_idle_busy got %b expected 0", busy0);
      else n_pass++;
      mode = 0;
   endtask

   task automatic test_hold_valid();
      int ve, nb, bad;
      mode = 1;
      run_window(0, ve, nb);
      n_checks++;
      if (ve !== 259) $display("FAIL hold_valid_edge got %0d expected 259", ve);
      else n_pass++;
      mode = 0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         start0 = k[0];
         @(posedge clk); #1;
         if (rv0 !== 1'b1 || busy0 !== 1'b1 || cnt0 !== {4{9'(W)}}) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles expected 0", bad);
      else n_pass++;
      start0 = 1'b1;
      rdy0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      rdy0 = 1'b0;
      n_checks++;
      if ({busy0, rv0} !== 2'b00) $display("FAIL hold_accept got %b expected 00", {busy0, rv0});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (busy0 !== 1'b0) $display("FAIL hold_start_ignored got busy %b expected 0", busy0);
      else n_pass++;
   endtask

   task automatic test_lat3();
      int ve, nb;
      run_window(3, ve, nb);
      n_checks++;
      if (ve !== 261) $display("FAIL lat3_valid_edge got %0d expected 261", ve);
      else n_pass++;
      n_checks++;
      if (nb !== W) $display("FAIL lat3_bit_en_cycles got %0d expected %0d", nb, W);
      else n_pass++;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (int'(cnt3[i][j]) !== 3) $display("FAIL lat3_count[%0d][%0d] got %0d expected 3", i, j, cnt3[i][j]);
            else n_pass++;
         end
      rdy3 = 1'b1;
      @(posedge clk); #1;
      rdy3 = 1'b0;
      n_checks++;
      if ({busy3, rv3} !== 2'b00) $display("FAIL lat3_accept got %b expected 00", {busy3, rv3});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int ve, nb;
      mode = 1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (102) @(posedge clk);
      #1;
      n_checks++;
      if (ben0 !== 1'b1) $display("FAIL midrst_in_run got bit_en %b expected 1", ben0);
      else n_pass++;
      #2;
      nrst = 1'b0;
      #1;
      n_checks++;
      if ({busy0, dnr0, ben0, rv0} !== 4'b0000) $display("FAIL midrst_ctrl got %b expected 0000", {busy0, dnr0, ben0, rv0});
      else n_pass++;
      n_checks++;
      if (cnt0 !== '0) $display("FAIL midrst_count got %h expected 0", cnt0);
      else n_pass++;
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); #1;
      repeat (4) sb_q.push_back(W);
      run_window(0, ve, nb);
      n_checks++;
      if (ve !== 259) $display("FAIL midrst_valid_edge got %0d expected 259", ve);
      else n_pass++;
      pop_check0("midrst_count");
      rdy0 = 1'b1;
      @(posedge clk); #1;
      rdy0 = 1'b0;
      mode = 0;
   endtask

`ifdef STOCH_DIV_CTRL_ABORT_EN
   task automatic test_abort();
      int seen;
      mode = 1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (52) @(posedge clk);
      #1;
      abort0 = 1'b1;
      @(posedge clk); #1;
      abort0 = 1'b0;
      n_checks++;
      if ({busy0, dnr0, ben0, rv0} !== 4'b0000) $display("FAIL abort_ctrl got %b expected 0000", {busy0, dnr0, ben0, rv0});
      else n_pass++;
      n_checks++;
      if (cnt0 !== '0) $display("FAIL abort_count got %h expected 0", cnt0);
      else n_pass++;
      seen = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (rv0 !== 1'b0 || busy0 !== 1'b0) seen++;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL abort_no_valid got %0d active cycles expected 0", seen);
      else n_pass++;
      abort0 = 1'b1;
      start0 = 1'b1;
      @(posedge clk); #1;
      abort0 = 1'b0;
      start0 = 1'b0;
      n_checks++;
      if (busy0 !== 1'b0) $display("FAIL abort_idle_start got busy %b expected 0", busy0);
      else n_pass++;
      mode = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_all_ones();
      test_toggle();
      test_hold_valid();
      test_lat3();
      test_reset_mid();
`ifdef STOCH_DIV_CTRL_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
